// File: rtl/fir_dsp_if.sv
// fir_dsp_if: groups the FIR MAC engine's per-cycle inputs and its outputs.
//   clk_en_i      clock enable
//   tap           signed coefficient for the current tap
//   tapnum        index of the current tap
//   signalWindow  signed sample window [0:NUM_TAPS-1]
//   result_o      saturated filtered sample
//   done          one-cycle completion pulse
// master: the driver of taps/window (reads results); slave: the MAC engine.
interface fir_dsp_if #(
  parameter int NUM_TAPS = 10,
  parameter int DATA_W   = 16,
  parameter int RES_W    = 33,
  parameter int IDX_W    = 8
);
  logic              clk_en_i;
  logic [DATA_W-1:0] tap;
  logic [IDX_W-1:0]  tapnum;
  logic [DATA_W-1:0] signalWindow [0:NUM_TAPS-1];
  logic [RES_W-1:0]  result_o;
  logic              done;

  modport master (
    output clk_en_i, tap, tapnum, signalWindow,
    input  result_o, done
  );

  modport slave (
    input  clk_en_i, tap, tapnum, signalWindow,
    output result_o, done
  );
endinterface

// File: rtl/fir_dsp.sv
// fir_dsp: 10-tap FIR multiply-accumulate engine for the audio EQ datapath.
// One tap per enabled cycle: tap * signalWindow[tapnum] is added to a running
// sum; tapnum==0 restarts the sum, the last tap publishes the saturated total
// on result_o with a registered one-cycle done pulse.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  synchronous active-low reset (wins over clk_en_i)
//   bus     fir_dsp_if slave: clk_en_i, tap, tapnum, signalWindow in;
//           result_o, done out
module fir_dsp #(
  parameter int NUM_TAPS = 10,
  parameter int DATA_W   = 16,
  parameter int RES_W    = 33,
  parameter int IDX_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  fir_dsp_if.slave    bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = RES_W + 4;

  // Saturation bounds of the RES_W signed range, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_TAPS);

  logic signed [ACC_W-1:0]  acc;
  logic        [DATA_W-1:0] win_sample;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic        [RES_W-1:0]  sat_sum;
  logic                     in_range;
  logic                     first_tap;
  logic                     last_tap;

  always_comb begin
    in_range  = (bus.tapnum < NUM_IDX);
    first_tap = (bus.tapnum == '0);
    last_tap  = (bus.tapnum == LAST_IDX);

    // Explicit compare-select keeps out-of-range indices from reading past the window.
    win_sample = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      if (bus.tapnum == IDX_W'(i)) win_sample = bus.signalWindow[i];
    end

    prod     = $signed(bus.tap) * $signed(win_sample);
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    sum      = (first_tap ? '0 : acc) + prod_ext;

    if (sum > RES_MAX)      sat_sum = RES_MAX[RES_W-1:0];
    else if (sum < RES_MIN) sat_sum = RES_MIN[RES_W-1:0];
    else                    sat_sum = sum[RES_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc          <= '0;
      bus.result_o <= '0;
      bus.done     <= 1'b0;
    end else if (bus.clk_en_i) begin
      if (in_range) begin
        acc      <= sum;
        bus.done <= last_tap;
        if (last_tap) bus.result_o <= sat_sum;
      end else begin
        bus.done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_dsp.sv
// tb_fir_dsp: directed self-checking bench for fir_dsp with hand-computed
// expected results (ramp 285, partial 32, saturation bounds).
module tb_fir_dsp;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] taps [0:9];

  always #5 clk = ~clk;

  fir_dsp_if #(.NUM_TAPS(10), .DATA_W(16), .RES_W(33), .IDX_W(8)) bus ();

  fir_dsp #(.NUM_TAPS(10), .DATA_W(16), .RES_W(33), .IDX_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents taps 0..9 in order; optionally stalls 3 cycles after tap stall_at.
  task automatic run_seq(input string tag, input int stall_at, input logic [32:0] prev_res);
    for (int k = 0; k < 10; k++) begin
      bus.tapnum = 8'(k);
      bus.tap    = taps[k];
      step();
      check({tag, "_done"}, {32'b0, bus.done}, {32'b0, (k == 9)});
      if (k < 9) check({tag, "_hold"}, bus.result_o, prev_res);
      if (k == stall_at) begin
        bus.clk_en_i = 1'b0;
        repeat (3) begin
          step();
          check({tag, "_stall_done"}, {32'b0, bus.done}, 33'd0);
        end
        bus.clk_en_i = 1'b1;
      end
    end
  endtask

  // After completion: done holds while disabled, then clears on an idle enabled edge.
  task automatic post_done(input string tag, input logic [32:0] res);
    bus.clk_en_i = 1'b0;
    step();
    check({tag, "_done_held"}, {32'b0, bus.done}, 33'd1);
    bus.clk_en_i = 1'b1;
    bus.tapnum   = 8'hFF;
    step();
    check({tag, "_done_clr"}, {32'b0, bus.done}, 33'd0);
    check({tag, "_res_kept"}, bus.result_o, res);
  endtask

  initial begin
    bus.clk_en_i = 1'b1;
    bus.tap      = '0;
    bus.tapnum   = 8'hFF;
    for (int i = 0; i < 10; i++) bus.signalWindow[i] = '0;
    rst_n = 1'b0;

    // T1 reset
    step();
    rst_n = 1'b1;
    check("rst_res", bus.result_o, 33'd0);
    check("rst_done", {32'b0, bus.done}, 33'd0);

    // T2 ramp
    for (int i = 0; i < 10; i++) begin
      bus.signalWindow[i] = 16'(i);
      taps[i] = 16'(i);
    end
    run_seq("ramp", -1, 33'd0);
    check("ramp_res", bus.result_o, 33'd285);
    post_done("ramp", 33'd285);

    // T3 partial: 5*4 + 2*1 + 3*2 + 4*1 = 32
    bus.signalWindow[0] = 16'd5; bus.signalWindow[1] = 16'd2;
    bus.signalWindow[2] = 16'd3; bus.signalWindow[3] = 16'd4;
    for (int i = 0; i < 10; i++) taps[i] = '0;
    taps[0] = 16'd4; taps[1] = 16'd1; taps[2] = 16'd2; taps[3] = 16'd1;
    run_seq("part", -1, 33'd285);
    check("part_res", bus.result_o, 33'd32);
    post_done("part", 33'd32);

    // T4 stall after tap 4
    for (int i = 0; i < 10; i++) begin
      bus.signalWindow[i] = 16'(i);
      taps[i] = 16'(i);
    end
    run_seq("stall", 4, 33'd32);
    check("stall_res", bus.result_o, 33'd285);
    post_done("stall", 33'd285);

    // Out-of-range index mid-sequence holds the accumulator
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        bus.tapnum = 8'd10;
        bus.tap    = 16'h7FFF;
        step();
        check("oor_done", {32'b0, bus.done}, 33'd0);
      end
      bus.tapnum = 8'(k);
      bus.tap    = taps[k];
      step();
    end
    check("oor_res", bus.result_o, 33'd285);
    post_done("oor", 33'd285);

    // T5 saturation: 10 * (-32768 * 32767) < -2^32
    for (int i = 0; i < 10; i++) begin
      bus.signalWindow[i] = 16'h8000;
      taps[i] = 16'h7FFF;
    end
    run_seq("satn", -1, 33'd285);
    check("satn_res", bus.result_o, 33'h1_0000_0000);
    post_done("satn", 33'h1_0000_0000);
    // 10 * (-32768 * -32768) > 2^32-1
    for (int i = 0; i < 10; i++) taps[i] = 16'h8000;
    run_seq("satp", -1, 33'h1_0000_0000);
    check("satp_res", bus.result_o, 33'h0_FFFF_FFFF);
    post_done("satp", 33'h0_FFFF_FFFF);

    // T6 restart: abandon after tap 5, restart at 0 with no idle cycle
    for (int i = 0; i < 10; i++) begin
      bus.signalWindow[i] = 16'(i);
      taps[i] = 16'(i);
    end
    for (int k = 0; k < 6; k++) begin
      bus.tapnum = 8'(k);
      bus.tap    = 16'h7FFF;
      step();
    end
    run_seq("rstrt", -1, 33'h0_FFFF_FFFF);
    check("rstrt_res", bus.result_o, 33'd285);
    // Back-to-back: 9 followed directly by 0
    run_seq("b2b", -1, 33'd285);
    check("b2b_res", bus.result_o, 33'd285);
    post_done("b2b", 33'd285);

    // Reset mid-sequence, with clk_en_i low to show reset wins
    for (int k = 0; k < 5; k++) begin
      bus.tapnum = 8'(k);
      bus.tap    = taps[k];
      step();
    end
    rst_n        = 1'b0;
    bus.clk_en_i = 1'b0;
    bus.tapnum   = 8'd5;
    step();
    rst_n        = 1'b1;
    bus.clk_en_i = 1'b1;
    check("mrst_res", bus.result_o, 33'd0);
    check("mrst_done", {32'b0, bus.done}, 33'd0);
    bus.tapnum = 8'hFF;
    step();
    check("mrst_idle_res", bus.result_o, 33'd0);
    check("mrst_idle_done", {32'b0, bus.done}, 33'd0);
    run_seq("mrst", -1, 33'd0);
    check("mrst_seq_res", bus.result_o, 33'd285);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
